// File: rtl/alu_pkg.sv
// Shared ALU definitions: op-select encoding, RV32I opcode/funct constants
// and the control-decode helper used by the decode/issue stage.
package alu_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned SEL_W    = 4;

    typedef enum logic [SEL_W-1:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLT   = 4'd2,
        ALU_SLTU  = 4'd3,
        ALU_AND   = 4'd4,
        ALU_OR    = 4'd5,
        ALU_XOR   = 4'd6,
        ALU_SLL   = 4'd7,
        ALU_SRL   = 4'd8,
        ALU_SRA   = 4'd9,
        ALU_LUI   = 4'd10,
        ALU_AUIPC = 4'd11
    } alu_sel_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SR      = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic     legal;
        alu_sel_e sel;
        logic     shift;
    } dec_ctrl_t;

    // alt selects SUB/SRA variants of the shared funct3 slots
    function automatic alu_sel_e op_sel(input logic [2:0] f3, input logic alt);
        alu_sel_e s;
        case (f3)
            F3_ADD_SUB: s = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:     s = ALU_SLL;
            F3_SLT:     s = ALU_SLT;
            F3_SLTU:    s = ALU_SLTU;
            F3_XOR:     s = ALU_XOR;
            F3_SR:      s = alt ? ALU_SRA : ALU_SRL;
            F3_OR:      s = ALU_OR;
            default:    s = ALU_AND;
        endcase
        return s;
    endfunction

    function automatic dec_ctrl_t decode_ctrl(input logic [6:0] opcode,
                                              input logic [2:0] f3,
                                              input logic [6:0] f7);
        dec_ctrl_t c;
        c = '{legal: 1'b0, sel: ALU_ADD, shift: 1'b0};
        case (opcode)
            OPC_OP: begin
                c.legal = (f7 == F7_ZERO) ||
                          ((f7 == F7_ALT) && ((f3 == F3_ADD_SUB) || (f3 == F3_SR)));
                c.sel   = op_sel(f3, f7[5]);
                c.shift = (f3 == F3_SLL) || (f3 == F3_SR);
            end
            OPC_OP_IMM: begin
                case (f3)
                    F3_SLL:  c.legal = (f7 == F7_ZERO);
                    F3_SR:   c.legal = (f7 == F7_ZERO) || (f7 == F7_ALT);
                    default: c.legal = 1'b1;
                endcase
                // immediate bit 30 only means "arithmetic" for right shifts
                c.sel   = op_sel(f3, (f3 == F3_SR) && f7[5]);
                c.shift = (f3 == F3_SLL) || (f3 == F3_SR);
            end
            OPC_LUI: begin
                c.legal = 1'b1;
                c.sel   = ALU_LUI;
            end
            OPC_AUIPC: begin
                c.legal = 1'b1;
                c.sel   = ALU_AUIPC;
            end
            default: ;
        endcase
        if (!c.legal) begin
            c.sel   = ALU_ADD;
            c.shift = 1'b0;
        end
        return c;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// I-type (sign-extended) and U-type (zero-extended, unshifted) immediate extraction.
module imm_gen #(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:12]     instr_i,
    output logic [XLEN-1:0]  imm_i_o,
    output logic [XLEN-1:0]  imm_u_o
);

    assign imm_i_o = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
    assign imm_u_o = XLEN'(instr_i[31:12]);

endmodule

// File: rtl/decode_issue_stage.sv
// RV32I integer decode/issue stage: decodes one instruction, selects ALU operands
// and hands a registered bundle to the ALU through a valid/ready skid-free register.
module decode_issue_stage
    import alu_pkg::*;
#(
    parameter int unsigned XLEN       = XLEN_DEF,
    parameter int unsigned SEL_SIZE   = 4,
    parameter int unsigned SHIFT_SIZE = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_in,
    output logic                  ready_out,
    input  logic [31:0]           instr,
    input  logic [XLEN-1:0]       pc,
    output logic [4:0]            rs1_addr,
    output logic [4:0]            rs2_addr,
    input  logic [XLEN-1:0]       rs1_data,
    input  logic [XLEN-1:0]       rs2_data,
    input  logic                  flush,
    input  logic                  ready_in,
    output logic                  valid_out,
    output logic                  alu_enable,
    output logic [SEL_SIZE-1:0]   alu_sel,
    output logic [SHIFT_SIZE:0]   alu_shift_amt,
    output logic [XLEN-1:0]       alu_data_a,
    output logic [XLEN-1:0]       alu_data_b,
    output logic [4:0]            rd_addr,
    output logic                  rd_write_en,
    output logic                  illegal_instr
);

    localparam int unsigned SHW = SHIFT_SIZE + 1;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rd_field;
    dec_ctrl_t       ctrl;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [SHW-1:0]  op_shamt;
    logic            load;

    logic                valid_q, valid_d;
    logic                en_q, en_d;
    logic [SEL_SIZE-1:0] sel_q, sel_d;
    logic [SHW-1:0]      shamt_q, shamt_d;
    logic [XLEN-1:0]     a_q, a_d;
    logic [XLEN-1:0]     b_q, b_d;
    logic [4:0]          rd_q, rd_d;
    logic                we_q, we_d;
    logic                ill_q, ill_d;

    assign opcode   = instr[6:0];
    assign rd_field = instr[11:7];
    assign funct3   = instr[14:12];
    assign funct7   = instr[31:25];
    assign rs1_addr = instr[19:15];
    assign rs2_addr = instr[24:20];
    assign ctrl     = decode_ctrl(opcode, funct3, funct7);

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr_i (instr[31:12]),
        .imm_i_o (imm_i),
        .imm_u_o (imm_u)
    );

    // Operand / shift-amount selection; illegal instructions leave everything zero
    always_comb begin
        op_a     = '0;
        op_b     = '0;
        op_shamt = '0;
        if (ctrl.legal) begin
            case (opcode)
                OPC_OP: begin
                    // the ALU computes b - a, so SUB swaps the register operands
                    if (ctrl.sel == ALU_SUB) begin
                        op_a = rs2_data;
                        op_b = rs1_data;
                    end else begin
                        op_a = rs1_data;
                        op_b = rs2_data;
                    end
                    if (ctrl.shift) op_shamt = SHW'(rs2_data[4:0]);
                end
                OPC_OP_IMM: begin
                    op_a = rs1_data;
                    op_b = imm_i;
                    if (ctrl.shift) op_shamt = SHW'(instr[24:20]);
                end
                OPC_LUI: begin
                    op_a = imm_u;
                end
                OPC_AUIPC: begin
                    op_a = imm_u;
                    op_b = pc;
                end
                default: ;
            endcase
        end
    end

    assign ready_out = !valid_q || ready_in;
    assign load      = valid_in && ready_out && !flush;

    // Output register next state: flush > load > drain > hold
    always_comb begin
        valid_d = valid_q;
        en_d    = en_q;
        sel_d   = sel_q;
        shamt_d = shamt_q;
        a_d     = a_q;
        b_d     = b_q;
        rd_d    = rd_q;
        we_d    = we_q;
        ill_d   = ill_q;
        if (flush) begin
            valid_d = 1'b0;
            en_d    = 1'b0;
            we_d    = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            en_d    = ctrl.legal;
            sel_d   = SEL_SIZE'(ctrl.sel);
            shamt_d = op_shamt;
            a_d     = op_a;
            b_d     = op_b;
            rd_d    = ctrl.legal ? rd_field : 5'd0;
            we_d    = ctrl.legal && (rd_field != 5'd0);
            ill_d   = !ctrl.legal;
        end else if (ready_in) begin
            valid_d = 1'b0;
            en_d    = 1'b0;
            we_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            en_q    <= 1'b0;
            sel_q   <= '0;
            shamt_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rd_q    <= '0;
            we_q    <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            en_q    <= en_d;
            sel_q   <= sel_d;
            shamt_q <= shamt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rd_q    <= rd_d;
            we_q    <= we_d;
            ill_q   <= ill_d;
        end
    end

    assign valid_out     = valid_q;
    assign alu_enable    = en_q;
    assign alu_sel       = sel_q;
    assign alu_shift_amt = shamt_q;
    assign alu_data_a    = a_q;
    assign alu_data_b    = b_q;
    assign rd_addr       = rd_q;
    assign rd_write_en   = we_q;
    assign illegal_instr = ill_q;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Scoreboard bench for decode_issue_stage: directed instructions push expected
// ALU bundles; a negedge monitor pops and compares on every accepted output.
module tb_decode_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_in, ready_out, flush, ready_in;
    logic [31:0] instr, pc, rs1_data, rs2_data;
    logic [4:0]  rs1_addr, rs2_addr;
    logic        valid_out, alu_enable, rd_write_en, illegal_instr;
    logic [3:0]  alu_sel;
    logic [5:0]  alu_shift_amt;
    logic [31:0] alu_data_a, alu_data_b;
    logic [4:0]  rd_addr;

    decode_issue_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .valid_in      (valid_in),
        .ready_out     (ready_out),
        .instr         (instr),
        .pc            (pc),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data),
        .flush         (flush),
        .ready_in      (ready_in),
        .valid_out     (valid_out),
        .alu_enable    (alu_enable),
        .alu_sel       (alu_sel),
        .alu_shift_amt (alu_shift_amt),
        .alu_data_a    (alu_data_a),
        .alu_data_b    (alu_data_b),
        .rd_addr       (rd_addr),
        .rd_write_en   (rd_write_en),
        .illegal_instr (illegal_instr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  sh;
        logic [4:0]  rd;
        logic        wen;
        logic        en;
        logic        ill;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic exp_t mk(input logic [3:0] sel, input logic [31:0] a,
                                input logic [31:0] b, input logic [5:0] sh,
                                input logic [4:0] rd, input logic wen,
                                input logic en, input logic ill);
        exp_t e;
        e.sel = sel; e.a = a; e.b = b; e.sh = sh;
        e.rd = rd; e.wen = wen; e.en = en; e.ill = ill;
        return e;
    endfunction

    function automatic exp_t cur();
        return mk(alu_sel, alu_data_a, alu_data_b, alu_shift_amt,
                  rd_addr, rd_write_en, alu_enable, illegal_instr);
    endfunction

    task automatic check(input string name, input exp_t got, input exp_t want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got sel=%0d a=%h b=%h sh=%0d rd=%0d wen=%b en=%b ill=%b, expected sel=%0d a=%h b=%h sh=%0d rd=%0d wen=%b en=%b ill=%b",
                     name, got.sel, got.a, got.b, got.sh, got.rd, got.wen, got.en, got.ill,
                     want.sel, want.a, want.b, want.sh, want.rd, want.wen, want.en, want.ill);
        end
    endtask

    task automatic check1(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // Monitor: every output the ALU accepts must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n && valid_out && ready_in) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_output: got sel=%0d a=%h with empty scoreboard, expected no output",
                         alu_sel, alu_data_a);
            end else begin
                check("scoreboard", cur(), exp_q.pop_front());
            end
        end
    end

    task automatic issue(input logic [31:0] ins, input logic [31:0] p,
                         input logic [31:0] r1, input logic [31:0] r2, input exp_t e);
        int n;
        n = 0;
        valid_in = 1'b1; instr = ins; pc = p; rs1_data = r1; rs2_data = r2;
        while (!ready_out && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ready_out) begin
            n_tests++;
            n_fail++;
            $display("FAIL issue_timeout: ready_out=%b, expected 1", ready_out);
        end
        exp_q.push_back(e);
        @(posedge clk); #1;
        valid_in = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check1("drain", 32'(exp_q.size()), 32'd0);
    endtask

    localparam exp_t ZERO = '0;

    initial begin
        exp_t held;
        valid_in = 1'b0; instr = '0; pc = '0; rs1_data = '0; rs2_data = '0;
        flush = 1'b0; ready_in = 1'b1;

        #12;
        check("reset_state", cur(), ZERO);
        check1("reset_valid", 32'(valid_out), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Back-to-back legal and illegal instructions, ALU always ready
        issue(32'hFFF08293, 32'h0, 32'h10, 32'h0,
              mk(4'd0, 32'h10, 32'hFFFF_FFFF, 6'd0, 5'd5, 1'b1, 1'b1, 1'b0));
        instr = 32'h402081B3; #1;
        check1("rs1_addr", 32'(rs1_addr), 32'd1);
        check1("rs2_addr", 32'(rs2_addr), 32'd2);
        issue(32'h402081B3, 32'h0, 32'd7, 32'd3,
              mk(4'd1, 32'd3, 32'd7, 6'd0, 5'd3, 1'b1, 1'b1, 1'b0));
        issue(32'h4030D213, 32'h0, 32'h8000_0000, 32'h0,
              mk(4'd9, 32'h8000_0000, 32'h0000_0403, 6'd3, 5'd4, 1'b1, 1'b1, 1'b0));
        issue(32'h00209333, 32'h0, 32'h1, 32'h25,
              mk(4'd7, 32'h1, 32'h25, 6'd5, 5'd6, 1'b1, 1'b1, 1'b0));
        issue(32'h4020D233, 32'h0, 32'hF000_0000, 32'h24,
              mk(4'd9, 32'hF000_0000, 32'h24, 6'd4, 5'd4, 1'b1, 1'b1, 1'b0));
        issue(32'h12345097, 32'h100, 32'h0, 32'h0,
              mk(4'd11, 32'h0001_2345, 32'h100, 6'd0, 5'd1, 1'b1, 1'b1, 1'b0));
        issue(32'hABCDE3B7, 32'h0, 32'h55, 32'h66,
              mk(4'd10, 32'h000A_BCDE, 32'h0, 6'd0, 5'd7, 1'b1, 1'b1, 1'b0));
        issue(32'h8000F493, 32'h0, 32'h1234_5678, 32'h0,
              mk(4'd4, 32'h1234_5678, 32'hFFFF_F800, 6'd0, 5'd9, 1'b1, 1'b1, 1'b0));
        issue(32'h00208033, 32'h0, 32'd5, 32'd6,
              mk(4'd0, 32'd5, 32'd6, 6'd0, 5'd0, 1'b0, 1'b1, 1'b0));
        issue(32'h00000003, 32'h40, 32'h11, 32'h22,
              mk(4'd0, 32'h0, 32'h0, 6'd0, 5'd0, 1'b0, 1'b0, 1'b1));
        issue(32'h40209333, 32'h0, 32'h11, 32'h22,
              mk(4'd0, 32'h0, 32'h0, 6'd0, 5'd0, 1'b0, 1'b0, 1'b1));
        issue(32'h4230D213, 32'h0, 32'h11, 32'h22,
              mk(4'd0, 32'h0, 32'h0, 6'd0, 5'd0, 1'b0, 1'b0, 1'b1));
        drain();
        check1("idle_enable", 32'(alu_enable), 32'd0);

        // Backpressure: hold for 3 cycles with a new instruction waiting, then flush
        ready_in = 1'b0;
        held = mk(4'd0, 32'h10, 32'hFFFF_FFFF, 6'd0, 5'd5, 1'b1, 1'b1, 1'b0);
        issue(32'hFFF08293, 32'h0, 32'h10, 32'h0, held);
        valid_in = 1'b1; instr = 32'h402081B3; rs1_data = 32'd9; rs2_data = 32'd1;
        for (int i = 0; i < 3; i++) begin
            check("hold_outputs", cur(), held);
            check1("hold_valid", 32'(valid_out), 32'd1);
            check1("hold_ready_out", 32'(ready_out), 32'd0);
            @(posedge clk); #1;
        end
        flush = 1'b1;
        #1;
        check1("flush_ready_out", 32'(ready_out), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; valid_in = 1'b0;
        exp_q.delete();
        check1("flush_valid", 32'(valid_out), 32'd0);
        check1("flush_enable", 32'(alu_enable), 32'd0);
        check1("flush_wen", 32'(rd_write_en), 32'd0);
        @(posedge clk); #1;
        check1("post_flush_valid", 32'(valid_out), 32'd0);

        ready_in = 1'b1;
        issue(32'hABCDE3B7, 32'h0, 32'h0, 32'h0,
              mk(4'd10, 32'h000A_BCDE, 32'h0, 6'd0, 5'd7, 1'b1, 1'b1, 1'b0));
        drain();

        // Asynchronous reset while an instruction is held
        ready_in = 1'b0;
        issue(32'h12345097, 32'h100, 32'h0, 32'h0,
              mk(4'd11, 32'h0001_2345, 32'h100, 6'd0, 5'd1, 1'b1, 1'b1, 1'b0));
        check1("pre_reset_valid", 32'(valid_out), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("async_reset", cur(), ZERO);
        check1("async_reset_valid", 32'(valid_out), 32'd0);
        #2 rst_n = 1'b1;
        ready_in = 1'b1;
        @(posedge clk); #1;
        issue(32'h402081B3, 32'h0, 32'd20, 32'd8,
              mk(4'd1, 32'd8, 32'd20, 6'd0, 5'd3, 1'b1, 1'b1, 1'b0));
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "timeout");
    end

endmodule
